rd_fram_unpack: RTL and testbench
=================================

// Module: rd_fram_unpack
// PURPOSE
//  Read-side counterpart of the frame write path. Fetches one frame from DDR as 256-bit burst beats,
//  buffers the beats, and unpacks each beat into eight 32-bit pixel words on a valid/ready stream.
//  Sits between the DDR read arbiter port and the video output / pixel consumer.
// PARAMETERS
//  DDR_DW      256     DDR beat width; must equal 8*PIX_DW
//  PIX_DW      32      output pixel word width
//  ADDR_W      28      DDR word address width (one address = one beat)
//  BUF_DEPTH   64      beat buffer depth (power of 2, >= 2*BURST_LEN)
//  BURST_LEN   16      beats per read request (1..BUF_DEPTH/2)
//  FRAME_BASE  0       DDR beat address of frame start
//  FRAME_BEATS 115200  beats per frame (1280x720x32b / 256b)
// PORTS
//  clk          in  1       single clock, all logic rising-edge
//  rst_n        in  1       asynchronous active-low reset
//  frame_start  in  1       1-cycle pulse: begin fetching a frame (accepted in IDLE only)
//  ddr_rd_req   out 1       read request; held until ddr_rd_ack
//  ddr_rd_addr  out ADDR_W  burst start beat address, stable while ddr_rd_req
//  ddr_rd_len   out 8       burst length in beats, stable while ddr_rd_req
//  ddr_rd_ack   in  1       request accepted (1 cycle)
//  ddr_rdata    in  DDR_DW  read beat
//  ddr_rvalid   in  1       beat valid (no back-pressure: must be stored)
//  ddr_rlast    in  1       last beat of burst
//  pix_data     out PIX_DW  unpacked pixel word
//  pix_valid    out 1       pix_data valid
//  pix_ready    in  1       consumer accepts on pix_valid & pix_ready
//  frame_busy   out 1       frame fetch/drain in progress
//  frame_done   out 1       1-cycle pulse after last pixel of frame handed off
//  underflow    out 1       sticky: pix_ready while busy with no pixel available; cleared by frame_start
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; buffer empty; lane=0; addr=FRAME_BASE.
//  FSM: IDLE -frame_start-> REQ; REQ -ack-> WAIT; WAIT -rlast beat-> REQ if beats_left>0 else DRAIN;
//   DRAIN -buffer empty & lane==0 & last pixel accepted-> IDLE (frame_done=1 that cycle+1, busy drops).
//  Request gating: in REQ, ddr_rd_req asserts only when free slots (BUF_DEPTH - count) >= ddr_rd_len;
//   ddr_rd_len = min(BURST_LEN, beats_left). One outstanding burst at a time.
//  On ack: addr += len, beats_left -= len (registered). Last burst of frame may be short.
//  Beat store: every ddr_rvalid beat written into buffer same cycle; count+1. rvalid in IDLE/DRAIN ignored.
//  Unpack: lane 0 = ddr_rdata[31:0] emitted first, lane 7 = [255:224] last. Lane advances on handshake;
//   beat popped on lane-7 handshake, lane wraps to 0. Simultaneous push and pop leave count unchanged.
//  pix_valid/pix_data registered output stage; first pixel valid 2 cycles after first beat stored.
//   pix_data held stable while pix_valid & !pix_ready.
//  Buffer full with rvalid cannot occur (gating); if it does, beat dropped (assertion in sim).
//  frame_start while busy: ignored. Reset mid-frame: immediate clear, no frame_done.
//  Address wraps modulo 2^ADDR_W (no special handling).
// STRUCTURE
//  fram_pkg: DDR_DW, PIX_DW, LANES=DDR_DW/PIX_DW, FSM state encoding (IDLE,REQ,WAIT,DRAIN).
//  Sub-module rd_fram_sbuf: single-clock FIFO (BUF_DEPTH x DDR_DW), count output, first-word-fall-through.
//  Top: FSM, address/beats_left counters, lane counter, output register.
// TESTING
//  1 FRAME_BEATS=32,BURST_LEN=16, ack next cycle, beats back-to-back, pix_ready=1 -> 2 requests
//    (addr 0 len 16, addr 16 len 16), 256 pixels in order, lane 0 first, single frame_done, underflow=0.
//  2 FRAME_BEATS=20 -> second request len 4 at addr 16; 160 pixels; frame_done once.
//  3 pix_ready=0 for 2000 cycles -> requests stall at count>BUF_DEPTH-16; no beat lost; release -> all pixels exact.
//  4 pix_ready random 30%, rvalid gaps random -> scoreboard matches pattern beat_addr*8+lane; pix_data stable when stalled.
//  5 slow DDR (ack 50 cycles), pix_ready=1 -> underflow=1 and stays set; next frame_start clears it.
//  6 rst_n low mid-burst -> outputs 0 asynchronously; new frame_start after release fetches from FRAME_BASE.

Source files
------------

// File: rtl/fram_pkg.sv
// Shared definitions for the frame read/unpack path.
//   DDR_DW / PIX_DW / LANES : default beat and pixel widths, pixels per beat
//   fsm_state_t             : fetch FSM encoding
//   min_u                   : unsigned minimum, used for burst length
package fram_pkg;

  localparam int DDR_DW = 256;
  localparam int PIX_DW = 32;
  localparam int LANES  = DDR_DW / PIX_DW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fsm_state_t;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/rd_fram_sbuf.sv
// Single-clock first-word-fall-through beat buffer.
//   clk, rst_n : clock, async active-low reset (pointers/count only)
//   wr_en      : push wr_data (ignored when full)
//   rd_en      : pop head (ignored when empty)
//   rd_data    : head entry, valid whenever !empty
//   count      : number of stored entries (0..DEPTH)
//   full/empty : status flags
module rd_fram_sbuf #(
  parameter int DW    = 256,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_wr, do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Storage carries no reset; the head is only consumed while !empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + AW'(1);
      if (do_rd) rptr <= rptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rptr];

endmodule

// File: rtl/rd_fram_unpack.sv
// Frame read path: fetches FRAME_BEATS beats from DDR in bursts, buffers them
// and unpacks each beat into LANES pixel words (lane 0 = low bits first).
//   frame_start            : start a frame fetch (IDLE only)
//   ddr_rd_req/addr/len    : burst request, held until ddr_rd_ack
//   ddr_rdata/rvalid/rlast : read beats, never back-pressured
//   pix_data/valid/ready   : registered pixel stream
//   frame_busy/frame_done  : fetch in progress / pulse after final pixel
//   underflow              : sticky starvation flag, cleared by frame_start
module rd_fram_unpack
  import fram_pkg::*;
#(
  parameter int DDR_DW      = fram_pkg::DDR_DW,
  parameter int PIX_DW      = fram_pkg::PIX_DW,
  parameter int ADDR_W      = 28,
  parameter int BUF_DEPTH   = 64,
  parameter int BURST_LEN   = 16,
  parameter int FRAME_BASE  = 0,
  parameter int FRAME_BEATS = 115200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  output logic              ddr_rd_req,
  output logic [ADDR_W-1:0] ddr_rd_addr,
  output logic [7:0]        ddr_rd_len,
  input  logic              ddr_rd_ack,
  input  logic [DDR_DW-1:0] ddr_rdata,
  input  logic              ddr_rvalid,
  input  logic              ddr_rlast,
  output logic [PIX_DW-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              frame_busy,
  output logic              frame_done,
  output logic              underflow
);

  localparam int NLANE  = DDR_DW / PIX_DW;
  localparam int LANE_W = $clog2(NLANE);
  localparam int CNT_W  = $clog2(BUF_DEPTH) + 1;
  localparam int BL_W   = $clog2(FRAME_BEATS + 1);

  fsm_state_t                    state;
  logic [BL_W-1:0]               beats_left;
  logic [ADDR_W-1:0]             addr;
  logic [LANE_W-1:0]             lane;
  logic                          started;
  logic [7:0]                    len_next;
  logic [CNT_W-1:0]              count, free;
  logic                          buf_full, buf_empty;
  logic                          push, pop, load, last_lane, drained;
  logic [NLANE-1:0][PIX_DW-1:0]  head;

  assign len_next  = 8'(min_u(32'(BURST_LEN), 32'(beats_left)));
  assign free      = CNT_W'(BUF_DEPTH) - count;
  // Beats outside an active fetch are stray and discarded.
  assign push      = ddr_rvalid && (state == REQ || state == WAIT);
  // Output register refills whenever it is empty or being handed off.
  assign load      = !buf_empty && (!pix_valid || pix_ready);
  assign last_lane = (lane == LANE_W'(NLANE - 1));
  assign pop       = load && last_lane;
  assign drained   = buf_empty && (lane == '0);

  assign ddr_rd_addr = addr;

  rd_fram_sbuf #(
    .DW    (DDR_DW),
    .DEPTH (BUF_DEPTH)
  ) u_sbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (ddr_rdata),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count),
    .full    (buf_full),
    .empty   (buf_empty)
  );

  // Fetch FSM: one outstanding burst, issued only when the whole burst fits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beats_left <= '0;
      addr       <= ADDR_W'(FRAME_BASE);
      ddr_rd_req <= 1'b0;
      ddr_rd_len <= '0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            state      <= REQ;
            beats_left <= BL_W'(FRAME_BEATS);
            addr       <= ADDR_W'(FRAME_BASE);
            frame_busy <= 1'b1;
          end
        end
        REQ: begin
          if (ddr_rd_req) begin
            if (ddr_rd_ack) begin
              ddr_rd_req <= 1'b0;
              addr       <= addr + ADDR_W'(ddr_rd_len);
              beats_left <= beats_left - BL_W'(ddr_rd_len);
              state      <= WAIT;
            end
          end else if (32'(free) >= 32'(len_next)) begin
            ddr_rd_req <= 1'b1;
            ddr_rd_len <= len_next;
          end
        end
        WAIT: begin
          if (push && ddr_rlast) state <= (beats_left != '0) ? REQ : DRAIN;
        end
        DRAIN: begin
          // Done once the buffer is empty and the final pixel leaves the output register.
          if (drained && (!pix_valid || pix_ready)) begin
            state      <= IDLE;
            frame_busy <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Unpack lanes into the registered output stage; track starvation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
      lane      <= '0;
      started   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (load) begin
        pix_data  <= head[lane];
        pix_valid <= 1'b1;
        lane      <= last_lane ? '0 : lane + LANE_W'(1);
        started   <= 1'b1;
      end else if (pix_ready) begin
        pix_valid <= 1'b0;
      end
      // Starvation only counts once pixels have started flowing and before the tail drains.
      if (state == IDLE && frame_start) begin
        underflow <= 1'b0;
        started   <= 1'b0;
      end else if (frame_busy && started && pix_ready && !pix_valid &&
                   !(state == DRAIN && drained)) begin
        underflow <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  a_no_drop: assert property (@(posedge clk) disable iff (!rst_n) !(push && buf_full));
`endif

endmodule

// File: tb/tb_rd_fram_unpack.sv
module tb_rd_fram_unpack;

  localparam int DDR_DW      = 256;
  localparam int PIX_DW      = 32;
  localparam int ADDR_W      = 28;
  localparam int BUF_DEPTH   = 32;
  localparam int BURST_LEN   = 8;
  localparam int FRAME_BASE  = 0;
  localparam int FRAME_BEATS = 44;   // 5 full bursts + one short burst of 4
  localparam int NPIX        = FRAME_BEATS * 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              frame_start = 1'b0;
  logic              ddr_rd_req;
  logic [ADDR_W-1:0] ddr_rd_addr;
  logic [7:0]        ddr_rd_len;
  logic              ddr_rd_ack = 1'b0;
  logic [DDR_DW-1:0] ddr_rdata = '0;
  logic              ddr_rvalid = 1'b0;
  logic              ddr_rlast = 1'b0;
  logic [PIX_DW-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready = 1'b0;
  logic              frame_busy, frame_done, underflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [PIX_DW-1:0] exp_q[$];
  int req_addr_q[$];
  int req_len_q[$];

  int ack_dly   = 0;
  int gap_max   = 0;
  int ready_pct = 100;
  int epoch     = 0;
  int pix_cnt   = 0;
  int done_cnt  = 0;

  bit                stall_prev = 1'b0;
  logic [PIX_DW-1:0] stall_data;
  logic [PIX_DW-1:0] exp_w;

  int m_a, m_n, m_ep, m_gap;

  always #5 clk = ~clk;

  rd_fram_unpack #(
    .DDR_DW(DDR_DW), .PIX_DW(PIX_DW), .ADDR_W(ADDR_W), .BUF_DEPTH(BUF_DEPTH),
    .BURST_LEN(BURST_LEN), .FRAME_BASE(FRAME_BASE), .FRAME_BEATS(FRAME_BEATS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .ddr_rd_req(ddr_rd_req), .ddr_rd_addr(ddr_rd_addr), .ddr_rd_len(ddr_rd_len),
    .ddr_rd_ack(ddr_rd_ack), .ddr_rdata(ddr_rdata), .ddr_rvalid(ddr_rvalid),
    .ddr_rlast(ddr_rlast), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .frame_busy(frame_busy), .frame_done(frame_done),
    .underflow(underflow)
  );

  // Consumer ready, re-drawn each cycle.
  always @(posedge clk) begin
    #1;
    pix_ready = ($urandom_range(99, 0) < ready_pct);
  end

  // DDR responder: beat at address a carries words a*8+lane; expected pixels pushed as beats go out.
  initial begin : ddr_model
    forever begin
      @(posedge clk); #1;
      if (rst_n && ddr_rd_req) begin
        m_a = int'(ddr_rd_addr); m_n = int'(ddr_rd_len); m_ep = epoch;
        for (int w = 0; w < ack_dly && epoch == m_ep; w++) begin @(posedge clk); #1; end
        if (epoch == m_ep) begin
          if (ack_dly > 0) begin
            n_checks++;
            if (!(ddr_rd_req === 1'b1 && int'(ddr_rd_addr) == m_a && int'(ddr_rd_len) == m_n)) begin
              n_fail++;
              $display("FAIL req_hold: req=%0b addr=%0d len=%0d, required req=1 addr=%0d len=%0d",
                       ddr_rd_req, ddr_rd_addr, ddr_rd_len, m_a, m_n);
            end
          end
          ddr_rd_ack = 1'b1;
          req_addr_q.push_back(m_a); req_len_q.push_back(m_n);
          @(posedge clk); #1;
          ddr_rd_ack = 1'b0;
          for (int i = 0; i < m_n && epoch == m_ep; i++) begin
            if (gap_max > 0) begin
              m_gap = $urandom_range(gap_max, 0);
              for (int g = 0; g < m_gap; g++) begin @(posedge clk); #1; end
            end
            if (epoch == m_ep) begin
              for (int l = 0; l < 8; l++) begin
                exp_w = 32'((m_a + i) * 8 + l);
                ddr_rdata[l*32 +: 32] = exp_w;
                exp_q.push_back(exp_w);
              end
              ddr_rvalid = 1'b1; ddr_rlast = (i == m_n - 1);
              @(posedge clk); #1;
              ddr_rvalid = 1'b0; ddr_rlast = 1'b0;
            end
          end
        end
      end
    end
  end

  // Scoreboard pop on handshake; stall stability; frame_done counting.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        n_checks++;
        if (pix_valid !== 1'b1 || pix_data !== stall_data) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%0b data=%h, required valid=1 data=%h", pix_valid, pix_data, stall_data);
        end
      end
      stall_prev = pix_valid && !pix_ready;
      stall_data = pix_data;
      if (pix_valid && pix_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pix_extra: got %h, required no pixel", pix_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (pix_data !== exp_w) begin
            n_fail++;
            $display("FAIL pix_data: got %h, required %h", pix_data, exp_w);
          end
        end
        pix_cnt++;
      end
      if (frame_done) done_cnt++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic start_frame();
    @(posedge clk); #1; frame_start = 1'b1;
    @(posedge clk); #1; frame_start = 1'b0;
  endtask

  task automatic wait_frame(input int budget, output bit ok);
    int d0;
    d0 = done_cnt; ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete(); req_addr_q.delete(); req_len_q.delete();
    pix_cnt = 0; done_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; #2; rst_n = 1'b0; #2;
    n_checks++;
    if ({ddr_rd_req, pix_valid, frame_busy, frame_done, underflow} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: req/valid/busy/done/uf=%b, required 00000",
               {ddr_rd_req, pix_valid, frame_busy, frame_done, underflow});
    end
    n_checks++;
    if (ddr_rd_addr !== ADDR_W'(FRAME_BASE) || ddr_rd_len !== 8'd0 || pix_data !== '0) begin
      n_fail++;
      $display("FAIL reset_buses: addr=%0d len=%0d pix=%h, required %0d 0 0", ddr_rd_addr, ddr_rd_len, pix_data, FRAME_BASE);
    end
    repeat (4) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (ddr_rd_req !== 1'b0 || frame_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: req=%0b busy=%0b, required 0 0", ddr_rd_req, frame_busy);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int a, rem, len, k;
    clear_sb(); ready_pct = 100; gap_max = 0; ack_dly = 0;
    start_frame();
    n_checks++;
    if (frame_busy !== 1'b1) begin n_fail++; $display("FAIL busy_set: got %0b, required 1", frame_busy); end
    repeat (40) @(posedge clk);
    #1; frame_start = 1'b1; @(posedge clk); #1; frame_start = 1'b0;   // must be ignored mid-frame
    wait_frame(3000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_timeout: no frame_done, required frame_done"); end
    n_checks++;
    if (pix_cnt != NPIX || exp_q.size() != 0) begin
      n_fail++; $display("FAIL basic_count: pixels=%0d left=%0d, required %0d 0", pix_cnt, exp_q.size(), NPIX);
    end
    n_checks++;
    if (done_cnt != 1 || frame_busy !== 1'b0 || underflow !== 1'b0) begin
      n_fail++; $display("FAIL basic_end: done=%0d busy=%0b uf=%0b, required 1 0 0", done_cnt, frame_busy, underflow);
    end
    n_checks++;
    if (req_addr_q.size() != 6) begin n_fail++; $display("FAIL basic_nreq: got %0d, required 6", req_addr_q.size()); end
    a = FRAME_BASE; rem = FRAME_BEATS; k = 0;
    while (rem > 0) begin
      len = (rem < BURST_LEN) ? rem : BURST_LEN;
      if (k < req_addr_q.size()) begin
        n_checks++;
        if (req_addr_q[k] != a || req_len_q[k] != len) begin
          n_fail++; $display("FAIL basic_req%0d: addr=%0d len=%0d, required %0d %0d", k, req_addr_q[k], req_len_q[k], a, len);
        end
      end
      a += len; rem -= len; k++;
    end
  endtask

  task automatic test_stall();
    bit ok;
    int a, rem, len, k;
    clear_sb(); ready_pct = 0; gap_max = 0; ack_dly = 0;
    start_frame();
    repeat (2000) @(posedge clk);
    #1;
    n_checks++;
    if (req_addr_q.size() != BUF_DEPTH / BURST_LEN || ddr_rd_req !== 1'b0) begin
      n_fail++; $display("FAIL stall_gate: reqs=%0d req=%0b, required %0d 0", req_addr_q.size(), ddr_rd_req, BUF_DEPTH / BURST_LEN);
    end
    n_checks++;
    if (exp_q.size() != BUF_DEPTH * 8 || pix_cnt != 0 || frame_busy !== 1'b1) begin
      n_fail++; $display("FAIL stall_state: pending=%0d pixels=%0d busy=%0b, required %0d 0 1", exp_q.size(), pix_cnt, frame_busy, BUF_DEPTH * 8);
    end
    ready_pct = 100;
    wait_frame(3000, ok);
    n_checks++;
    if (!ok || pix_cnt != NPIX || exp_q.size() != 0 || done_cnt != 1) begin
      n_fail++; $display("FAIL stall_release: ok=%0b pixels=%0d left=%0d done=%0d, required 1 %0d 0 1", ok, pix_cnt, exp_q.size(), done_cnt, NPIX);
    end
    a = FRAME_BASE; rem = FRAME_BEATS; k = 0;
    while (rem > 0) begin
      len = (rem < BURST_LEN) ? rem : BURST_LEN;
      n_checks++;
      if (k >= req_addr_q.size() || req_addr_q[k] != a || req_len_q[k] != len) begin
        n_fail++; $display("FAIL stall_req%0d: missing or wrong, required addr=%0d len=%0d", k, a, len);
      end
      a += len; rem -= len; k++;
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int f = 0; f < 2; f++) begin
      clear_sb(); ready_pct = 30; gap_max = 3; ack_dly = 2;
      start_frame();
      wait_frame(20000, ok);
      n_checks++;
      if (!ok || pix_cnt != NPIX || exp_q.size() != 0 || done_cnt != 1) begin
        n_fail++; $display("FAIL random%0d: ok=%0b pixels=%0d left=%0d done=%0d, required 1 %0d 0 1", f, ok, pix_cnt, exp_q.size(), done_cnt, NPIX);
      end
    end
  endtask

  task automatic test_underflow();
    bit ok;
    clear_sb(); ready_pct = 100; gap_max = 0; ack_dly = 100;
    start_frame();
    wait_frame(5000, ok);
    n_checks++;
    if (!ok || pix_cnt != NPIX || underflow !== 1'b1) begin
      n_fail++; $display("FAIL uf_set: ok=%0b pixels=%0d uf=%0b, required 1 %0d 1", ok, pix_cnt, underflow, NPIX);
    end
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (underflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %0b, required 1", underflow); end
    clear_sb(); ack_dly = 0;
    start_frame();
    n_checks++;
    if (underflow !== 1'b0) begin n_fail++; $display("FAIL uf_clear: got %0b, required 0", underflow); end
    wait_frame(3000, ok);
    n_checks++;
    if (!ok || underflow !== 1'b0 || pix_cnt != NPIX) begin
      n_fail++; $display("FAIL uf_clean_frame: ok=%0b uf=%0b pixels=%0d, required 1 0 %0d", ok, underflow, pix_cnt, NPIX);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_sb(); ready_pct = 30; gap_max = 1; ack_dly = 0;
    start_frame();
    repeat (40) @(posedge clk);
    #3; rst_n = 1'b0; epoch++;
    #1;
    n_checks++;
    if ({ddr_rd_req, pix_valid, frame_busy, frame_done, underflow} !== 5'b0 || pix_data !== '0) begin
      n_fail++; $display("FAIL async_reset: req/valid/busy/done/uf=%b pix=%h, required 00000 0",
                         {ddr_rd_req, pix_valid, frame_busy, frame_done, underflow}, pix_data);
    end
    repeat (6) @(posedge clk);
    #1; clear_sb(); rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt != 0 || frame_busy !== 1'b0 || ddr_rd_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_quiet: done=%0d busy=%0b req=%0b, required 0 0 0", done_cnt, frame_busy, ddr_rd_req);
    end
    ready_pct = 100; gap_max = 0;
    start_frame();
    wait_frame(3000, ok);
    n_checks++;
    if (!ok || req_addr_q.size() == 0 || pix_cnt != NPIX || exp_q.size() != 0) begin
      n_fail++; $display("FAIL refetch: ok=%0b reqs=%0d pixels=%0d left=%0d, required 1 6 %0d 0", ok, req_addr_q.size(), pix_cnt, exp_q.size(), NPIX);
    end else begin
      n_checks++;
      if (req_addr_q[0] != FRAME_BASE) begin
        n_fail++; $display("FAIL refetch_base: addr=%0d, required %0d", req_addr_q[0], FRAME_BASE);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_random();
    test_underflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
